// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator built from phase accumulators.
// Enables run only once locked; any increment write restarts all channels phase-aligned.
module clken_gen #(
  parameter int               CHANNELS    = 4,
  parameter int               ACC_W       = 24,
  parameter logic [ACC_W-1:0] DEFAULT_INC = {1'b1, {(ACC_W-1){1'b0}}},
  parameter int               LOCK_CYCLES = 16,
  localparam int              CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [ACC_W-1:0]    wr_inc,
  input  logic                sync,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] phase_msb,
  output logic                locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES);

  typedef enum logic {LOCKING = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    inc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_d [CHANNELS];
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic [CHANNELS-1:0] phase_q, phase_d;
  logic [ACC_W:0]      sum;
  logic                wr_valid;
  logic                run;

  // wr_en is a fire-and-forget strobe with no ready: a write with an in-range
  // channel is always taken on the edge that samples it; others are dropped.
  assign wr_valid = wr_en && (int'(wr_ch) < CHANNELS);

  // A write always wins, so it both relocks and suppresses a coincident sync.
  assign run = (state_q == LOCKED) && !wr_valid && !sync;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wr_valid) begin
      state_d = LOCKING;
      cnt_d   = '0;
    end else if (state_q == LOCKING) begin
      if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
        state_d = LOCKED;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    sum     = '0;
    ce_d    = '0;
    phase_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sum        = {1'b0, acc_q[k]} + {1'b0, inc_q[k]};
      acc_d[k]   = run ? sum[ACC_W-1:0] : '0;
      ce_d[k]    = run & sum[ACC_W];
      phase_d[k] = run & sum[ACC_W-1];
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= LOCKING;
      cnt_q   <= '0;
      ce_q    <= '0;
      phase_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        acc_q[k] <= '0;
        inc_q[k] <= DEFAULT_INC >> k;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      phase_q <= phase_d;
      for (int k = 0; k < CHANNELS; k++) begin
        acc_q[k] <= acc_d[k];
        if (wr_valid && (int'(wr_ch) == k)) inc_q[k] <= wr_inc;
      end
    end
  end

  assign ce        = ce_q;
  assign phase_msb = phase_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_clken_gen.sv
// Directed bench for clken_gen: vector table for reset/lock/sync, then hand sequences
// for relock on write, disabled channel, reset mid-lock, write+sync and an ignored index.
module tb_clken_gen;

  localparam int LOCK = 16;

  logic        refclk = 1'b0;
  logic        rst = 1'b1, wr_en = 1'b0, sync = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [23:0] wr_inc = '0;
  logic [3:0]  ce, phase_msb;
  logic        locked;

  logic        rst3 = 1'b1, wr_en3 = 1'b0, sync3 = 1'b0;
  logic [1:0]  wr_ch3 = '0;
  logic [23:0] wr_inc3 = '0;
  logic [2:0]  ce3, phase3;
  logic        locked3;

  // clock/reset block
  always #5 refclk = ~refclk;

  clken_gen dut (
    .refclk(refclk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_inc(wr_inc),
    .sync(sync), .ce(ce), .phase_msb(phase_msb), .locked(locked)
  );

  clken_gen #(.CHANNELS(3)) dut3 (
    .refclk(refclk), .rst(rst3), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_inc(wr_inc3),
    .sync(sync3), .ce(ce3), .phase_msb(phase3), .locked(locked3)
  );

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [23:0] wr_inc;
    logic        sync;
    logic        exp_locked;
    logic [3:0]  exp_ce;
    logic [3:0]  exp_ph;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [3:0] def_ce [16];
  logic [3:0] def_ph [16];
  logic [3:0] wr1_ce [16];
  logic [7:0] ws_exp [8];
  logic [2:0] d3_ce  [8];

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic we, input logic [1:0] ch, input logic [23:0] inc,
                      input logic s, input logic lk, input logic [3:0] c, input logic [3:0] p);
    vec_t v;
    v = '{r, we, ch, inc, s, lk, c, p};
    vecs.push_back(v);
  endtask

  task automatic do_write(input string name, input logic [1:0] ch, input logic [23:0] inc,
                          input logic s);
    wr_en = 1'b1; wr_ch = ch; wr_inc = inc; sync = s;
    tick();
    wr_en = 1'b0; sync = 1'b0;
    check({name, "_locked_drop"}, 32'(locked), 0);
    check({name, "_ce_clear"}, 32'(ce), 0);
  endtask

  task automatic relock_check(input string name, input int sync_at);
    int   rise;
    logic noisy;
    rise = -1;
    noisy = 1'b0;
    for (int i = 1; i <= 2 * LOCK && rise < 0; i++) begin
      sync = (i == sync_at);
      tick();
      sync = 1'b0;
      if (locked === 1'b1) rise = i;
      if (ce !== 4'b0 || phase_msb !== 4'b0) noisy = 1'b1;
    end
    check({name, "_rise"}, rise, LOCK);
    check({name, "_quiet"}, 32'(noisy), 0);
  endtask

  task automatic drain(input string name, input logic [7:0] mask);
    logic [7:0] e;
    int         m;
    m = 1;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("%s_m%0d", name, m), 32'({phase_msb, ce} & mask), 32'(e & mask));
      m++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    int n0, n1, n2, n3;
    logic seen2;

    def_ce = '{4'h0, 4'h1, 4'h0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h7,
               4'h0, 4'h1, 4'h0, 4'h3, 4'h0, 4'h1, 4'h0, 4'hF};
    def_ph = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
               4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    wr1_ce = '{4'h0, 4'h1, 4'h0, 4'h3, 4'h0, 4'h1, 4'h2, 4'h5,
               4'h0, 4'h3, 4'h0, 4'h1, 4'h2, 4'h1, 4'h0, 4'hF};
    ws_exp = '{8'h90, 8'hA9, 8'hB8, 8'hCB, 8'hD8, 8'hE9, 8'hF8, 8'h8F};
    d3_ce  = '{3'h0, 3'h1, 3'h0, 3'h3, 3'h0, 3'h1, 3'h0, 3'h7};

    // reset, lock wait, default pattern, then a sync on odd locked cycle 17
    push(1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    for (int i = 1; i < LOCK; i++) push(0, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    push(0, 0, 0, 0, 0, 1, 4'h0, 4'h0);
    for (int m = 0; m < 16; m++) push(0, 0, 0, 0, 0, 1, def_ce[m], def_ph[m]);
    push(0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
    for (int m = 0; m < 4; m++) push(0, 0, 0, 0, 0, 1, def_ce[m], def_ph[m]);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; wr_en = vecs[i].wr_en; wr_ch = vecs[i].wr_ch;
      wr_inc = vecs[i].wr_inc; sync = vecs[i].sync;
      tick();
      check($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
      check($sformatf("vec%0d_ce", i), 32'(ce), 32'(vecs[i].exp_ce));
      check($sformatf("vec%0d_phase", i), 32'(phase_msb), 32'(vecs[i].exp_ph));
    end
    rst = 1'b0; wr_en = 1'b0; sync = 1'b0;

    // ch1 at 1/3 rate; other channels restart aligned
    do_write("wr1", 2'd1, 24'h555555, 1'b0);
    relock_check("relock_wr1", 0);
    for (int m = 0; m < 16; m++) exp_q.push_back({def_ph[m], wr1_ce[m]});
    drain("wr1_seq", 8'hDF);

    // ch2 disabled; a sync during locking must not stretch the lock time
    do_write("wr2", 2'd2, 24'h0, 1'b0);
    relock_check("relock_wr2", 5);
    n0 = 0; n1 = 0; n2 = 0; n3 = 0; seen2 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      n0 += int'(ce[0]); n1 += int'(ce[1]); n2 += int'(ce[2]); n3 += int'(ce[3]);
      if (phase_msb[2] !== 1'b0) seen2 = 1'b1;
    end
    check("off_ce0_count", n0, 500);
    check("off_ce1_count", n1, 333);
    check("off_ce2_count", n2, 0);
    check("off_ce3_count", n3, 62);
    check("off_phase2_seen", 32'(seen2), 0);

    // reset while locking at count 7 restores defaults and a full lock
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("midlock_locked", 32'(locked), 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_locked", 32'(locked), 0);
    relock_check("relock_rst", 0);
    for (int m = 0; m < 16; m++) exp_q.push_back({def_ph[m], def_ce[m]});
    drain("rst_defaults", 8'hFF);

    // write and sync together: write wins; ch3 at full rate
    do_write("wrsync", 2'd3, 24'hFFFFFF, 1'b1);
    relock_check("relock_wrsync", 0);
    for (int m = 0; m < 8; m++) exp_q.push_back(ws_exp[m]);
    drain("wrsync_seq", 8'hFF);

    // out-of-range channel on a 3-channel instance is ignored
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    rise = -1;
    for (int i = 1; i <= 2 * LOCK && rise < 0; i++) begin
      tick();
      if (locked3 === 1'b1) rise = i;
    end
    check("dut3_rise", rise, LOCK);
    for (int m = 1; m <= 8; m++) begin
      wr_en3 = (m == 3); wr_ch3 = 2'd3; wr_inc3 = 24'h0;
      tick();
      wr_en3 = 1'b0;
      check($sformatf("dut3_ce_m%0d", m), 32'(ce3), 32'(d3_ce[m-1]));
      check($sformatf("dut3_locked_m%0d", m), 32'(locked3), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
